// File: rtl/fp_mul_arbiter.sv
// fp_mul_arbiter: round-robin arbiter sharing one combinational FP32 multiplier
// among NUM_REQ requesters through a two-stage (operand / result) pipeline.
// Optional exception statistics are compiled in with `define FP_MUL_ARB_STATS_EN.
// fp_mul: single-precision multiply, truncated mantissa, denormals treated as zero.

module fp_mul (
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic [31:0] prod
);

   logic        sign;
   logic        a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
   logic [24:0] p_hi;
   logic [9:0]  e_tmp;

   assign sign   = a[31] ^ b[31];
   assign a_zero = (a[30:23] == 8'h00);
   assign b_zero = (b[30:23] == 8'h00);
   assign a_inf  = (a[30:23] == 8'hFF) && (a[22:0] == 23'h0);
   assign b_inf  = (b[30:23] == 8'hFF) && (b[22:0] == 23'h0);
   assign a_nan  = (a[30:23] == 8'hFF) && (a[22:0] != 23'h0);
   assign b_nan  = (b[30:23] == 8'hFF) && (b[22:0] != 23'h0);

   // Upper 25 bits of the 48-bit significand product; bit 24 is the normalise flag
   assign p_hi = 25'((48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]})) >> 23);

   // Classify special operands first, then normalise, truncate and range-check the exponent
   always_comb begin
      prod  = 32'h0;
      e_tmp = {2'b00, a[30:23]} + {2'b00, b[30:23]} + {9'd0, p_hi[24]};
      if (a_nan || b_nan || (a_zero && b_inf) || (a_inf && b_zero)) begin
         prod = {sign, 8'hFF, 23'h7FFFFF};
      end else if (a_inf || b_inf) begin
         prod = {sign, 8'hFF, 23'h0};
      end else if (a_zero || b_zero) begin
         prod = {sign, 31'h0};
      end else if (e_tmp >= 10'd382) begin
         prod = {sign, 8'hFF, 23'h0};
      end else if (e_tmp <= 10'd127) begin
         prod = {sign, 31'h0};
      end else begin
         prod = {sign, 8'(e_tmp - 10'd127), (p_hi[24] ? p_hi[23:1] : p_hi[22:0])};
      end
   end

endmodule

module fp_mul_arbiter #(
   parameter  int NUM_REQ = 4,
   parameter  int TAG_W   = 4,
   localparam int ID_W    = $clog2(NUM_REQ)
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [NUM_REQ-1:0]       req_vld,
   input  logic [NUM_REQ*32-1:0]    req_a,
   input  logic [NUM_REQ*32-1:0]    req_b,
   input  logic [NUM_REQ*TAG_W-1:0] req_tag,
   output logic [NUM_REQ-1:0]       req_rdy,
   output logic                     rsp_vld,
   input  logic                     rsp_rdy,
   output logic [31:0]              rsp_prod,
   output logic [ID_W-1:0]          rsp_id,
   output logic [TAG_W-1:0]         rsp_tag
`ifdef FP_MUL_ARB_STATS_EN
   ,
   output logic [15:0]              exc_cnt,
   input  logic                     stats_clr
`endif
);

   logic [31:0]      a_arr   [NUM_REQ];
   logic [31:0]      b_arr   [NUM_REQ];
   logic [TAG_W-1:0] tag_arr [NUM_REQ];

   logic [ID_W-1:0]  rr_ptr;
   logic             grant_hit;
   logic [ID_W-1:0]  grant_idx;
   logic [ID_W-1:0]  idx;
   int               cand;
   logic             accept;
   logic             s1_adv, s2_adv;

   logic             s1_vld;
   logic [31:0]      s1_a, s1_b;
   logic [ID_W-1:0]  s1_id;
   logic [TAG_W-1:0] s1_tag;

   logic             s2_vld;
   logic [31:0]      s2_prod;
   logic [ID_W-1:0]  s2_id;
   logic [TAG_W-1:0] s2_tag;

   logic [31:0]      mul_prod;

   // Unpack the flat request buses into per-requester arrays
   always_comb begin
      for (int i = 0; i < NUM_REQ; i++) begin
         a_arr[i]   = req_a[32*i +: 32];
         b_arr[i]   = req_b[32*i +: 32];
         tag_arr[i] = req_tag[TAG_W*i +: TAG_W];
      end
   end

   assign s2_adv = ~s2_vld | rsp_rdy;
   assign s1_adv = ~s1_vld | s2_adv;

   // Round-robin search from rr_ptr; the grant is only exposed when S1 can take it
   always_comb begin
      grant_hit = 1'b0;
      grant_idx = '0;
      idx       = '0;
      cand      = 0;
      req_rdy   = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         cand = int'(rr_ptr) + i;
         if (cand >= NUM_REQ) begin
            cand = cand - NUM_REQ;
         end
         idx = ID_W'(cand);
         if (!grant_hit && req_vld[idx]) begin
            grant_hit = 1'b1;
            grant_idx = idx;
         end
      end
      if (grant_hit && s1_adv && rst_n) begin
         req_rdy[grant_idx] = 1'b1;
      end
   end

   assign accept = grant_hit & s1_adv & rst_n;

   // Advance the round-robin pointer past the requester just served
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr <= '0;
      end else if (accept) begin
         rr_ptr <= (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
      end
   end

   // Operand stage: capture the granted request, or empty out when nothing is granted
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_vld <= 1'b0;
         s1_a   <= '0;
         s1_b   <= '0;
         s1_id  <= '0;
         s1_tag <= '0;
      end else if (s1_adv) begin
         s1_vld <= accept;
         if (accept) begin
            s1_a   <= a_arr[grant_idx];
            s1_b   <= b_arr[grant_idx];
            s1_id  <= grant_idx;
            s1_tag <= tag_arr[grant_idx];
         end
      end
   end

   fp_mul u_fp_mul (
      .a    (s1_a),
      .b    (s1_b),
      .prod (mul_prod)
   );

   // Result stage: take the multiplier output whenever downstream lets the pipe move
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s2_vld  <= 1'b0;
         s2_prod <= '0;
         s2_id   <= '0;
         s2_tag  <= '0;
      end else if (s2_adv) begin
         s2_vld  <= s1_vld;
         s2_prod <= mul_prod;
         s2_id   <= s1_id;
         s2_tag  <= s1_tag;
      end
   end

   assign rsp_vld  = s2_vld;
   assign rsp_prod = s2_prod;
   assign rsp_id   = s2_id;
   assign rsp_tag  = s2_tag;

`ifdef FP_MUL_ARB_STATS_EN
   // Saturating count of INF/NaN products entering the result stage; clear wins
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         exc_cnt <= 16'h0;
      end else if (stats_clr) begin
         exc_cnt <= 16'h0;
      end else if (s2_adv && s1_vld && (mul_prod[30:23] == 8'hFF) && (exc_cnt != 16'hFFFF)) begin
         exc_cnt <= exc_cnt + 16'h1;
      end
   end
`endif

endmodule

// File: tb/tb_fp_mul_arbiter.sv
// tb_fp_mul_arbiter: directed checks of fp_mul_arbiter (product values, round-robin
// order, backpressure, exceptions and async reset). Stats checks compile in with
// FP_MUL_ARB_STATS_EN.

module tb_fp_mul_arbiter;

   localparam int NUM_REQ = 4;
   localparam int TAG_W   = 4;
   localparam int ID_W    = 2;

   logic                     clk;
   logic                     rst_n;
   logic [NUM_REQ-1:0]       req_vld;
   logic [NUM_REQ*32-1:0]    req_a;
   logic [NUM_REQ*32-1:0]    req_b;
   logic [NUM_REQ*TAG_W-1:0] req_tag;
   logic [NUM_REQ-1:0]       req_rdy;
   logic                     rsp_vld;
   logic                     rsp_rdy;
   logic [31:0]              rsp_prod;
   logic [ID_W-1:0]          rsp_id;
   logic [TAG_W-1:0]         rsp_tag;
`ifdef FP_MUL_ARB_STATS_EN
   logic [15:0]              exc_cnt;
   logic                     stats_clr;
`endif

   int checks;
   int errors;

   logic [31:0] fair_prod [4];
   int          exp_g;
   int          prev_g;

   fp_mul_arbiter #(.NUM_REQ(NUM_REQ), .TAG_W(TAG_W)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .req_vld  (req_vld),
      .req_a    (req_a),
      .req_b    (req_b),
      .req_tag  (req_tag),
      .req_rdy  (req_rdy),
      .rsp_vld  (rsp_vld),
      .rsp_rdy  (rsp_rdy),
      .rsp_prod (rsp_prod),
      .rsp_id   (rsp_id),
      .rsp_tag  (rsp_tag)
`ifdef FP_MUL_ARB_STATS_EN
      ,
      .exc_cnt  (exc_cnt),
      .stats_clr(stats_clr)
`endif
   );

   // Free-running 10 ns clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Hard time limit so the bench can never hang
   initial begin
      #200000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed=%h expected=%h", name, obs, exp);
      end
   endtask

   task automatic setReq(input int i, input logic [31:0] a, input logic [31:0] b, input logic [TAG_W-1:0] tag);
      req_a[32*i +: 32]       = a;
      req_b[32*i +: 32]       = b;
      req_tag[TAG_W*i +: TAG_W] = tag;
   endtask

   task automatic applyStimulus(input logic [NUM_REQ-1:0] vld, input logic rdy);
      req_vld = vld;
      rsp_rdy = rdy;
      #1;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkRsp(input string name, input logic vld, input logic [31:0] prod,
                           input logic [ID_W-1:0] id, input logic [TAG_W-1:0] tag);
      checkOutput({name, "_vld"}, 32'(rsp_vld), 32'(vld));
      if (vld) begin
         checkOutput({name, "_prod"}, rsp_prod, prod);
         checkOutput({name, "_id"}, 32'(rsp_id), 32'(id));
         checkOutput({name, "_tag"}, 32'(rsp_tag), 32'(tag));
      end
   endtask

   initial begin
      checks  = 0;
      errors  = 0;
      rst_n   = 1'b0;
      req_a   = '0;
      req_b   = '0;
      req_tag = '0;
`ifdef FP_MUL_ARB_STATS_EN
      stats_clr = 1'b0;
`endif
      fair_prod[0] = 32'h40000000;
      fair_prod[1] = 32'h40800000;
      fair_prod[2] = 32'h40C00000;
      fair_prod[3] = 32'h41000000;

      // Reset state, with a request already pending
      setReq(0, 32'h40400000, 32'h40000000, 4'd5);
      applyStimulus(4'b0001, 1'b1);
      checkOutput("rst_req_rdy", 32'(req_rdy), 32'h0);
      checkOutput("rst_rsp_vld", 32'(rsp_vld), 32'h0);
      checkOutput("rst_rsp_prod", rsp_prod, 32'h0);
      checkOutput("rst_rsp_id", 32'(rsp_id), 32'h0);
      checkOutput("rst_rsp_tag", 32'(rsp_tag), 32'h0);
      tick();
      tick();
      rst_n = 1'b1;
      #1;

      // Single op 3.0 * 2.0, two-cycle latency
      checkOutput("single_grant", 32'(req_rdy), 32'b0001);
      tick();
      checkOutput("single_lat1_vld", 32'(rsp_vld), 32'h0);
      applyStimulus(4'b0000, 1'b1);
      tick();
      checkRsp("single", 1'b1, 32'h40C00000, 2'd0, 4'd5);
      tick();
      checkOutput("single_drained", 32'(rsp_vld), 32'h0);

      // Sign and fraction: -2.0*1.5 then 1.5*1.5, pointer now at 1
      setReq(1, 32'hC0000000, 32'h3FC00000, 4'd9);
      setReq(2, 32'h3FC00000, 32'h3FC00000, 4'd3);
      applyStimulus(4'b0110, 1'b1);
      checkOutput("sign_grant1", 32'(req_rdy), 32'b0010);
      tick();
      checkOutput("sign_grant2", 32'(req_rdy), 32'b0100);
      tick();
      applyStimulus(4'b0000, 1'b1);
      checkRsp("neg_mul", 1'b1, 32'hC0400000, 2'd1, 4'd9);
      tick();
      checkRsp("frac_mul", 1'b1, 32'h40100000, 2'd2, 4'd3);
      tick();
      checkOutput("sign_drained", 32'(rsp_vld), 32'h0);

      // Fairness: all requesters busy, pointer at 3 so order is 3,0,1,2,3,0,1,2
      setReq(0, 32'h3F800000, 32'h40000000, 4'd8);
      setReq(1, 32'h40000000, 32'h40000000, 4'd9);
      setReq(2, 32'h40400000, 32'h40000000, 4'd10);
      setReq(3, 32'h40800000, 32'h40000000, 4'd11);
      applyStimulus(4'b1111, 1'b1);
      prev_g = 0;
      for (int i = 0; i < 8; i++) begin
         exp_g = (3 + i) % 4;
         checkOutput($sformatf("fair_grant%0d", i), 32'(req_rdy), 32'(1 << exp_g));
         tick();
         if (i > 0) begin
            checkRsp($sformatf("fair_rsp%0d", i), 1'b1, fair_prod[prev_g], ID_W'(prev_g), TAG_W'(8 + prev_g));
         end
         prev_g = exp_g;
      end

      // Backpressure: S2 holds requester 1, S1 holds requester 2
      applyStimulus(4'b1111, 1'b0);
      checkOutput("bp_rdy_now", 32'(req_rdy), 32'h0);
      for (int i = 0; i < 5; i++) begin
         tick();
         checkOutput($sformatf("bp_rdy%0d", i), 32'(req_rdy), 32'h0);
         checkRsp($sformatf("bp_hold%0d", i), 1'b1, 32'h40800000, 2'd1, 4'd9);
      end
      applyStimulus(4'b1111, 1'b1);
      checkOutput("bp_release_grant", 32'(req_rdy), 32'b1000);
      tick();
      applyStimulus(4'b0000, 1'b1);
      checkRsp("bp_out2", 1'b1, 32'h40C00000, 2'd2, 4'd10);
      checkOutput("bp_idle_rdy", 32'(req_rdy), 32'h0);
      tick();
      checkRsp("bp_out3", 1'b1, 32'h41000000, 2'd3, 4'd11);
      tick();
      checkOutput("bp_drained", 32'(rsp_vld), 32'h0);

      // Exceptions: 0*INF gives NaN pattern, -INF*2 gives -INF; pointer at 0
      setReq(0, 32'h7F800000, 32'h00000000, 4'd1);
      setReq(1, 32'hFF800000, 32'h40000000, 4'd2);
      applyStimulus(4'b0011, 1'b1);
      checkOutput("exc_grant0", 32'(req_rdy), 32'b0001);
      tick();
      checkOutput("exc_grant1", 32'(req_rdy), 32'b0010);
      tick();
      applyStimulus(4'b0000, 1'b1);
      checkRsp("exc_nan", 1'b1, 32'h7FFFFFFF, 2'd0, 4'd1);
      tick();
      checkRsp("exc_ninf", 1'b1, 32'hFF800000, 2'd1, 4'd2);
`ifdef FP_MUL_ARB_STATS_EN
      checkOutput("exc_cnt2", 32'(exc_cnt), 32'd2);
      stats_clr = 1'b1;
      tick();
      stats_clr = 1'b0;
      checkOutput("exc_cnt_clr", 32'(exc_cnt), 32'd0);
`else
      tick();
`endif
      checkOutput("exc_drained", 32'(rsp_vld), 32'h0);

      // Async reset with both stages full; pointer at 2
      setReq(2, 32'h40400000, 32'h40000000, 4'd7);
      setReq(3, 32'h3FC00000, 32'h3FC00000, 4'd6);
      applyStimulus(4'b1100, 1'b0);
      checkOutput("ar_grant2", 32'(req_rdy), 32'b0100);
      tick();
      checkOutput("ar_grant3", 32'(req_rdy), 32'b1000);
      tick();
      checkRsp("ar_full", 1'b1, 32'h40C00000, 2'd2, 4'd7);
      checkOutput("ar_full_rdy", 32'(req_rdy), 32'h0);
      #3;
      rst_n = 1'b0;
      #1;
      checkOutput("ar_rsp_vld", 32'(rsp_vld), 32'h0);
      checkOutput("ar_req_rdy", 32'(req_rdy), 32'h0);
      checkOutput("ar_rsp_prod", rsp_prod, 32'h0);
      #2;
      rst_n = 1'b1;
      applyStimulus(4'b1111, 1'b1);
      checkOutput("ar_first_grant", 32'(req_rdy), 32'b0001);
      tick();
      checkOutput("ar_second_grant", 32'(req_rdy), 32'b0010);
      checkOutput("ar_no_stale_rsp", 32'(rsp_vld), 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, errors);
      $finish;
   end

endmodule
